// File: rtl/stopwatch_controller.sv
// Two-button stopwatch controller: debounced start/stop and lap/reset buttons driving
// run/pause/lap/clear sequencing. `STOPWATCH_CTRL_LONGPRESS_EN enables long-press clear on B.
module stopwatch_controller #(
  parameter int DEBOUNCE_MS  = 20,
  parameter int LONGPRESS_MS = 1000
) (
  input  logic       clk1KHz,
  input  logic       reset,
  input  logic       btn_a,
  input  logic       btn_b,
  input  logic [9:0] ms_in,
  input  logic [5:0] sec_in,
  input  logic [5:0] min_in,
  output logic       start,
  output logic       stop,
  output logic       clear,
  output logic [1:0] state,
  output logic [9:0] disp_ms,
  output logic [5:0] disp_sec,
  output logic [5:0] disp_min,
  output logic [3:0] lap_count
);

  localparam int CW = $clog2(DEBOUNCE_MS + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_MS - 1);
  localparam logic [CW-1:0] DB_ONE  = CW'(1);

  if (DEBOUNCE_MS < 1 || LONGPRESS_MS <= DEBOUNCE_MS) begin : gBadParams
    $error("stopwatch_controller: need DEBOUNCE_MS >= 1 and LONGPRESS_MS > DEBOUNCE_MS");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, RUNNING = 2'd1, PAUSED = 2'd2, LAP_HOLD = 2'd3} state_e;

  logic [1:0]         sync1_q, sync2_q, stable_q, stable_d;
  logic [1:0][CW-1:0] cnt_q, cnt_d;
  logic               aEvt, bEvt, bLong;

  state_e     state_q, state_d;
  logic       start_q, start_d, stop_q, stop_d, clear_q, clear_d;
  logic       pendClear_q, pendClear_d;
  logic [9:0] lapMs_q, lapMs_d, dispMs_q, dispMs_d;
  logic [5:0] lapSec_q, lapSec_d, dispSec_q, dispSec_d;
  logic [5:0] lapMin_q, lapMin_d, dispMin_q, dispMin_d;
  logic [3:0] lapCnt_q, lapCnt_d;

  always_ff @(posedge clk1KHz or posedge reset) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= {btn_b, btn_a};
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // Any return of the synchronized level to the accepted level restarts the count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == DB_LAST) stable_d[i] = sync2_q[i];
        else                     cnt_d[i]    = cnt_q[i] + DB_ONE;
      end
    end
  end

  assign aEvt = stable_d[0] & ~stable_q[0];

`ifdef STOPWATCH_CTRL_LONGPRESS_EN
  localparam int LW = $clog2(LONGPRESS_MS + 1);
  localparam logic [LW-1:0] LP_LAST = LW'(LONGPRESS_MS - 1);
  localparam logic [LW-1:0] LP_MAX  = LW'(LONGPRESS_MS);
  localparam logic [LW-1:0] LP_ONE  = LW'(1);

  logic [LW-1:0] holdCnt_q, holdCnt_d;
  logic          longDone_q, longDone_d, bFall;

  always_ff @(posedge clk1KHz or posedge reset) begin
    if (reset) begin
      holdCnt_q  <= '0;
      longDone_q <= 1'b0;
    end else begin
      holdCnt_q  <= holdCnt_d;
      longDone_q <= longDone_d;
    end
  end

  // Short B acts on debounced release unless the hold already produced a long event.
  always_comb begin
    bFall     = stable_q[1] & ~stable_d[1];
    holdCnt_d = '0;
    if (sync2_q[1]) holdCnt_d = (holdCnt_q == LP_MAX) ? holdCnt_q : holdCnt_q + LP_ONE;
    bLong      = sync2_q[1] && (holdCnt_q == LP_LAST);
    bEvt       = bFall && !longDone_q;
    longDone_d = longDone_q;
    if (bLong)      longDone_d = 1'b1;
    else if (bFall) longDone_d = 1'b0;
  end
`else
  assign bEvt  = stable_d[1] & ~stable_q[1];
  assign bLong = 1'b0;
`endif

  always_ff @(posedge clk1KHz or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      start_q     <= 1'b0;
      stop_q      <= 1'b0;
      clear_q     <= 1'b0;
      pendClear_q <= 1'b0;
      lapMs_q     <= '0;
      lapSec_q    <= '0;
      lapMin_q    <= '0;
      lapCnt_q    <= '0;
      dispMs_q    <= '0;
      dispSec_q   <= '0;
      dispMin_q   <= '0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      stop_q      <= stop_d;
      clear_q     <= clear_d;
      pendClear_q <= pendClear_d;
      lapMs_q     <= lapMs_d;
      lapSec_q    <= lapSec_d;
      lapMin_q    <= lapMin_d;
      lapCnt_q    <= lapCnt_d;
      dispMs_q    <= dispMs_d;
      dispSec_q   <= dispSec_d;
      dispMin_q   <= dispMin_d;
    end
  end

  // A has priority over B whenever both fire in the same cycle.
  always_comb begin
    state_d = state_q;
    if (pendClear_q) state_d = IDLE;
    else begin
      case (state_q)
        IDLE:     if (aEvt) state_d = RUNNING;
        RUNNING:  if (aEvt || bLong) state_d = PAUSED;
                  else if (bEvt)     state_d = LAP_HOLD;
        LAP_HOLD: if (aEvt || bLong) state_d = PAUSED;
                  else if (bEvt)     state_d = RUNNING;
        PAUSED:   if (aEvt)          state_d = RUNNING;
                  else if (bEvt || bLong) state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    start_d     = 1'b0;
    stop_d      = 1'b0;
    clear_d     = 1'b0;
    pendClear_d = 1'b0;
    lapMs_d     = lapMs_q;
    lapSec_d    = lapSec_q;
    lapMin_d    = lapMin_q;
    lapCnt_d    = lapCnt_q;
    if (pendClear_q) begin
      clear_d = 1'b1;
    end else begin
      case (state_q)
        IDLE:     if (aEvt) start_d = 1'b1;
        RUNNING: begin
          if (aEvt) stop_d = 1'b1;
          else if (bLong) begin
            stop_d      = 1'b1;
            pendClear_d = 1'b1;
          end else if (bEvt) begin
            lapMs_d  = ms_in;
            lapSec_d = sec_in;
            lapMin_d = min_in;
            if (lapCnt_q != 4'd15) lapCnt_d = lapCnt_q + 4'd1;
          end
        end
        LAP_HOLD: begin
          if (aEvt) stop_d = 1'b1;
          else if (bLong) begin
            stop_d      = 1'b1;
            pendClear_d = 1'b1;
          end
        end
        PAUSED: begin
          if (aEvt) start_d = 1'b1;
          else if (bEvt || bLong) clear_d = 1'b1;
        end
        default: ;
      endcase
    end
    if (clear_d) begin
      lapMs_d  = '0;
      lapSec_d = '0;
      lapMin_d = '0;
      lapCnt_d = '0;
    end
    dispMs_d  = (state_q == LAP_HOLD) ? lapMs_q  : ms_in;
    dispSec_d = (state_q == LAP_HOLD) ? lapSec_q : sec_in;
    dispMin_d = (state_q == LAP_HOLD) ? lapMin_q : min_in;
  end

  assign start     = start_q;
  assign stop      = stop_q;
  assign clear     = clear_q;
  assign state     = state_q;
  assign disp_ms   = dispMs_q;
  assign disp_sec  = dispSec_q;
  assign disp_min  = dispMin_q;
  assign lap_count = lapCnt_q;

endmodule

// File: tb/tb_stopwatch_controller.sv
// Scoreboard bench for stopwatch_controller: stimulus queues expected pulses, a monitor
// pops them whenever start/stop/clear is seen; state, display and lap count checked directly.
module tb_stopwatch_controller;

  localparam int DB = 20;
  localparam int LP = 1000;
  localparam logic [2:0] P_START = 3'b100;
  localparam logic [2:0] P_STOP  = 3'b010;
  localparam logic [2:0] P_CLEAR = 3'b001;

  logic       clk1KHz = 1'b0;
  logic       reset = 1'b1;
  logic       btn_a = 1'b0;
  logic       btn_b = 1'b0;
  logic [9:0] ms_in = '0;
  logic [5:0] sec_in = '0;
  logic [5:0] min_in = '0;
  logic       start, stop, clear;
  logic [1:0] state;
  logic [9:0] disp_ms;
  logic [5:0] disp_sec, disp_min;
  logic [3:0] lap_count;

  int cyc = 0;
  int checks = 0;
  int fails = 0;

  typedef struct {
    logic [2:0] pulses;
    logic [1:0] st;
    int         at;
  } exp_t;
  exp_t expQ[$];

  stopwatch_controller #(.DEBOUNCE_MS(DB), .LONGPRESS_MS(LP)) dut (
    .clk1KHz(clk1KHz), .reset(reset), .btn_a(btn_a), .btn_b(btn_b),
    .ms_in(ms_in), .sec_in(sec_in), .min_in(min_in),
    .start(start), .stop(stop), .clear(clear), .state(state),
    .disp_ms(disp_ms), .disp_sec(disp_sec), .disp_min(disp_min),
    .lap_count(lap_count)
  );

  always #5 clk1KHz = ~clk1KHz;

  always @(posedge clk1KHz) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Every control pulse the DUT emits must match the oldest queued expectation.
  always @(negedge clk1KHz) begin : monitor
    exp_t e;
    if (!reset && (start || stop || clear)) begin
      if (expQ.size() == 0) begin
        checks++;
        fails++;
        $display("[TB] FAIL unexpected_pulse: got start/stop/clear=%b%b%b state=%0d at cycle %0d, required no pulse",
                 start, stop, clear, state, cyc);
      end else begin
        e = expQ.pop_front();
        checkOutput("pulse_kind", {29'd0, start, stop, clear}, {29'd0, e.pulses});
        checkOutput("pulse_state", {30'd0, state}, {30'd0, e.st});
        checkOutput("pulse_cycle", cyc, e.at);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk1KHz);
    #2;
  endtask

  task automatic expectPulse(input logic [2:0] p, input logic [1:0] st, input int at);
    exp_t e;
    e.pulses = p;
    e.st     = st;
    e.at     = at;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic a, input logic b, input int hold,
                               input logic want, input logic [2:0] p, input logic [1:0] st);
    if (want) expectPulse(p, st, cyc + DB + 2);
    btn_a = a;
    btn_b = b;
    tick(hold);
    btn_a = 1'b0;
    btn_b = 1'b0;
    tick(30);
  endtask

  initial begin
    tick(3);
    reset = 1'b0;
    tick(1);
    checkOutput("reset_state", {30'd0, state}, 32'd0);
    checkOutput("reset_pulses", {29'd0, start, stop, clear}, 32'd0);
    checkOutput("reset_disp", {10'd0, disp_ms, disp_sec, disp_min}, 32'd0);
    checkOutput("reset_laps", {28'd0, lap_count}, 32'd0);

    for (int i = 0; i < 5; i++) begin
      btn_a = 1'b1;
      tick(5);
      btn_a = 1'b0;
      tick(5);
    end
    tick(30);
    checkOutput("bounce_state", {30'd0, state}, 32'd0);

    applyStimulus(1'b1, 1'b0, 30, 1'b1, P_START, 2'd1);

    ms_in = 10'd123; sec_in = 6'd4; min_in = 6'd5;
    applyStimulus(1'b0, 1'b1, 30, 1'b0, 3'b000, 2'd0);
    checkOutput("lap1_state", {30'd0, state}, 32'd3);
    checkOutput("lap1_count", {28'd0, lap_count}, 32'd1);
    ms_in = 10'd500; sec_in = 6'd30; min_in = 6'd40;
    tick(3);
    checkOutput("lap1_frozen", {10'd0, disp_ms, disp_sec, disp_min}, {10'd0, 10'd123, 6'd4, 6'd5});

    applyStimulus(1'b0, 1'b1, 30, 1'b0, 3'b000, 2'd0);
    checkOutput("lap_release_state", {30'd0, state}, 32'd1);
    checkOutput("lap_release_live", {10'd0, disp_ms, disp_sec, disp_min}, {10'd0, 10'd500, 6'd30, 6'd40});

    applyStimulus(1'b1, 1'b0, 30, 1'b1, P_STOP, 2'd2);
    checkOutput("paused_laps", {28'd0, lap_count}, 32'd1);
    applyStimulus(1'b0, 1'b1, 30, 1'b1, P_CLEAR, 2'd0);
    checkOutput("clear_state", {30'd0, state}, 32'd0);
    checkOutput("clear_laps", {28'd0, lap_count}, 32'd0);

    applyStimulus(1'b1, 1'b0, 30, 1'b1, P_START, 2'd1);
`ifndef STOPWATCH_CTRL_LONGPRESS_EN
    applyStimulus(1'b1, 1'b1, 30, 1'b1, P_STOP, 2'd2);
    checkOutput("simul_state", {30'd0, state}, 32'd2);
    checkOutput("simul_laps", {28'd0, lap_count}, 32'd0);
    applyStimulus(1'b1, 1'b0, 30, 1'b1, P_START, 2'd1);
`endif

    for (int i = 0; i < 17; i++) begin
      ms_in  = 10'(i * 10 + 7);
      sec_in = 6'(i);
      min_in = 6'(i + 1);
      applyStimulus(1'b0, 1'b1, 30, 1'b0, 3'b000, 2'd0);
      if (i < 16) applyStimulus(1'b0, 1'b1, 30, 1'b0, 3'b000, 2'd0);
    end
    checkOutput("lap17_state", {30'd0, state}, 32'd3);
    checkOutput("lap17_count", {28'd0, lap_count}, 32'd15);
    ms_in = 10'd1; sec_in = 6'd2; min_in = 6'd3;
    tick(2);
    checkOutput("lap17_disp", {10'd0, disp_ms, disp_sec, disp_min}, {10'd0, 10'd167, 6'd16, 6'd17});

    applyStimulus(1'b1, 1'b0, 30, 1'b1, P_STOP, 2'd2);
    checkOutput("laphold_stop_live", {10'd0, disp_ms, disp_sec, disp_min}, {10'd0, 10'd1, 6'd2, 6'd3});
    applyStimulus(1'b0, 1'b1, 30, 1'b1, P_CLEAR, 2'd0);
    checkOutput("clear2_laps", {28'd0, lap_count}, 32'd0);

`ifdef STOPWATCH_CTRL_LONGPRESS_EN
    applyStimulus(1'b1, 1'b0, 30, 1'b1, P_START, 2'd1);
    expectPulse(P_STOP, 2'd2, cyc + LP + 2);
    expectPulse(P_CLEAR, 2'd0, cyc + LP + 3);
    btn_b = 1'b1;
    tick(1100);
    btn_b = 1'b0;
    tick(40);
    checkOutput("long_state", {30'd0, state}, 32'd0);
    checkOutput("long_laps", {28'd0, lap_count}, 32'd0);
`endif

    ms_in = 10'd77; sec_in = 6'd8; min_in = 6'd9;
    tick(2);
    expectPulse(P_START, 2'd1, cyc + DB + 2);
    btn_a = 1'b1;
    tick(DB + 2);
    @(negedge clk1KHz);
    #1;
    checkOutput("start_before_reset", {31'd0, start}, 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("reset_kills_start", {31'd0, start}, 32'd0);
    checkOutput("reset_mid_state", {30'd0, state}, 32'd0);
    checkOutput("reset_mid_disp", {10'd0, disp_ms, disp_sec, disp_min}, 32'd0);
    checkOutput("reset_mid_laps", {28'd0, lap_count}, 32'd0);
    btn_a = 1'b0;
    tick(5);
    reset = 1'b0;
    tick(30);
    checkOutput("post_reset_state", {30'd0, state}, 32'd0);
    checkOutput("queue_drained", expQ.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/stopwatch_controller.md
# stopwatch_controller

Two-button user controller that sequences the stopwatch datapath. Debounces a start/stop button and a lap/reset button, runs the run/pause/lap/clear state machine, and emits single-cycle `start`, `stop` and `clear` pulses to the datapath. It also captures lap times and drives a frozen-or-live time display. It runs entirely in the 1 kHz domain, between the board buttons and the stopwatch counter block.

## Interface
- `DEBOUNCE_MS`, 20: consecutive stable cycles required to accept a press or release (≥1).
- `LONGPRESS_MS`, 1000: hold time for a long press (only with `STOPWATCH_CTRL_LONGPRESS_EN`; must exceed `DEBOUNCE_MS`).
- `clk1KHz` input 1: controller clock.
- `reset` input 1: asynchronous, active-high.
- `btn_a` input 1: raw start/stop button, active-high, asynchronous.
- `btn_b` input 1: raw lap/reset button, active-high, asynchronous.
- `ms_in` input 10: live datapath milliseconds, 0..999.
- `sec_in` input 6: live datapath seconds, 0..59.
- `min_in` input 6: live datapath minutes, 0..59.
- `start` output 1: one-cycle pulse to datapath start.
- `stop` output 1: one-cycle pulse to datapath stop.
- `clear` output 1: one-cycle registered pulse to the datapath reset.
- `state` output 2: 0 IDLE, 1 RUNNING, 2 PAUSED, 3 LAP_HOLD.
- `disp_ms` output 10: displayed milliseconds.
- `disp_sec` output 6: displayed seconds.
- `disp_min` output 6: displayed minutes.
- `lap_count` output 4: laps taken since clear; saturates at 15.

## Operation
- **Button front end, per button:** 2-flop synchronizer, then a debounce counter that restarts on every change of the synchronized level.
  - A press event fires once, when the level has been high for `DEBOUNCE_MS` cycles.
  - The button then re-arms only after it has been low for `DEBOUNCE_MS` cycles.
  - Glitches shorter than `DEBOUNCE_MS` produce no event.
- **FSM** (A = A press event, B = B press event):
  - IDLE: A → RUNNING, pulse `start`. B is ignored.
  - RUNNING: A → PAUSED, pulse `stop`. B → LAP_HOLD, latch `ms_in`/`sec_in`/`min_in` into the lap registers, increment `lap_count`.
  - LAP_HOLD: B → RUNNING, display returns to live. A → PAUSED, pulse `stop`, display returns to live.
  - PAUSED: A → RUNNING, pulse `start`. B → IDLE, pulse `clear`, zero the lap registers and `lap_count`.
- **Simultaneous A and B events in one cycle:** A is acted on and B is discarded; B must be pressed again.
- **Display outputs** are registered:
  - In LAP_HOLD they show the lap registers.
  - In every other state they show the inputs as sampled on the previous edge.
- **`lap_count`** holds at 15. Further laps still latch new lap times.
- **Pulses:** `start`, `stop` and `clear` are never asserted together. Each is high for exactly one `clk1KHz` cycle, which is wide enough for the fast-domain edge detectors in the datapath.

## Timing
- **Reset values:** `state`=IDLE; `start`=`stop`=`clear`=0; all `disp_*`=0; `lap_count`=0; lap registers 0; synchronizers and debounce counters 0.
- `reset` asserted mid-operation aborts any pulse immediately and returns to IDLE.
- **Press latency:** a control pulse and the matching state change appear at edge `DEBOUNCE_MS`+2, counting the first edge that samples the button high as edge 1. With the defaults this is edge 22.
- **Display latency:** `disp_*` reflects a new state one edge after the state change. In LAP_HOLD it shows the value captured at the transition edge.
- **No back-pressure:** events are consumed in the same cycle they fire.

## Configuration
- **`STOPWATCH_CTRL_LONGPRESS_EN` defined:**
  - A short B press fires its B event on its debounced release (release complete).
  - B held for `LONGPRESS_MS` cycles (synchronized) fires a long event at that cycle and suppresses the short event on release.
  - In RUNNING, PAUSED or LAP_HOLD, a long event issues `clear` and goes to IDLE. RUNNING and LAP_HOLD first pulse `stop`, then `clear` on the next cycle.
  - In IDLE a long event is ignored.
- **Not defined:** B fires on press as described above, and `LONGPRESS_MS` is unused.

## Test plan
- Reset, then hold `btn_a` high 30 cycles → `start` is high for exactly cycle 22 and `state`=1. Release for 30 cycles, press A again → `stop` pulse at edge 22, `state`=2.
- `btn_a` bounce of 5-cycle high/low bursts for 50 cycles, then low → no pulse, `state` stays 0.
- RUNNING with `ms_in`=123, `sec_in`=4, `min_in`=5, press B → `state`=3, `disp_*`=123/4/5 frozen while the inputs change, `lap_count`=1. Press B again → display live.
- PAUSED, press B → `clear` for one cycle, `state`=0, `lap_count`=0. Also: A and B rising in the same cycle from RUNNING → only `stop` pulses, `state`=2.
- 17 laps → `lap_count`=15 and the last lap values are displayed. Assert `reset` while a `start` pulse is high → pulse drops at once and all outputs return to their reset values.
- With `STOPWATCH_CTRL_LONGPRESS_EN`: in RUNNING hold B 1100 cycles → at edge `LONGPRESS_MS`+2 `stop` pulses, next cycle `clear` pulses, `state`=0, and no lap is taken on release.
